stack_engine: RTL and testbench
===============================

# stack_engine

Parametrised LIFO stack engine for the stack tile. It is the datapath behind the `push`/`pop`/`instructionDone` pins of the top level. It generalises the single push/pop interface into a WIDTH-bit, DEPTH-entry stack with a small opcode set: push, pop, replace, dup, swap and clear. It also provides occupancy flags, sticky error flags and a one-cycle completion pulse. It sits between the top-level pin decode and the output mux that drives `uo_out`.

## Interface
- `WIDTH`, default 8: data word width in bits, minimum 1.
- `DEPTH`, default 8: number of stack entries, minimum 2.
- `CW`, default `$clog2(DEPTH+1)`: width of the occupancy count. It is derived and must not be overridden.
- `clk`, input, 1: the single clock; all logic is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `op_valid`, input, 1: command strobe; a command is accepted on every cycle this is high.
- `op`, input, 3: opcode. 0 NOP, 1 PUSH, 2 POP, 3 REPLACE, 4 DUP, 5 SWAP, 6 CLEAR, 7 reserved (behaves as NOP).
- `data_in`, input, WIDTH: operand for PUSH and REPLACE.
- `top`, output, WIDTH: current top-of-stack, registered; it reads 0 when empty.
- `next`, output, WIDTH: entry below the top, registered; it reads 0 when count < 2.
- `count`, output, CW: number of valid entries, 0..DEPTH.
- `empty`, output, 1: high when count == 0.
- `full`, output, 1: high when count == DEPTH.
- `done`, output, 1: one-cycle pulse marking completion of an accepted non-NOP command.
- `err`, output, 1: one-cycle pulse, coincident with `done`, when the command was rejected.
- `overflow`, output, 1: sticky; set by a rejected PUSH or DUP.
- `underflow`, output, 1: sticky; set by a rejected POP, REPLACE, DUP or SWAP.

## Operation
- Storage is a DEPTH×WIDTH register array plus a CW-bit stack pointer `sp`, where `sp` equals `count`. Entry `sp-1` is the top.
- Every command completes in one cycle; there is no busy state. The state is updated on the rising edge where `op_valid` is high.
- PUSH: if not full, write `data_in` at `sp` and increment `sp`. If full, the stack is unchanged, `err` pulses and `overflow` is set.
- POP: if not empty, decrement `sp`; popped data is not cleared. If empty, the stack is unchanged, `err` pulses and `underflow` is set.
- REPLACE: if not empty, overwrite the top with `data_in` and leave count unchanged. This is the registered equivalent of a simultaneous push and pop. If empty, `underflow` is set and `err` pulses.
- DUP: requires count ≥ 1 and not full; it copies the top to `sp` and increments `sp`.
  - Empty gives `underflow`.
  - Full gives `overflow`.
  - Empty has priority only when DEPTH would allow both, which is impossible, so the flags are exclusive.
- SWAP: requires count ≥ 2; it exchanges entries `sp-1` and `sp-2`. Otherwise `underflow` is set.
- CLEAR: sets `sp` to 0 and clears `overflow` and `underflow`. It never errors, and `done` pulses.
- NOP and reserved opcodes, or `op_valid` low: no state change, and neither `done` nor `err` pulses.
- A rejected command never alters the array, `sp`, `top` or `next`.
- `top` and `next` are recomputed from the post-update state, so they are valid in the same cycle as `done`.
- Array entries are not reset; only `sp`, the flags and the outputs are reset.

## Timing
- Reset: when `rst` is high at an edge, in the following cycle:
  - `sp` = 0, `top` = 0, `next` = 0, `count` = 0;
  - `empty` = 1, `full` = 0;
  - `done` = 0, `err` = 0, `overflow` = 0, `underflow` = 0.
- `rst` overrides any command on the same edge; the command is dropped with no `done`.
- Latency: for a command accepted at edge N, `done`, `err`, `top`, `next`, `count`, `empty`, `full` and the sticky flags all reflect it after edge N. Latency is 1 cycle.
- Back-to-back commands are allowed on every cycle. Each sees the state left by the previous one.
- `done` and `err` are high for exactly one cycle per accepted command. Consecutive commands produce consecutive pulses.
- Reset mid-sequence: the stack empties at once. The next command after reset sees count 0.

## Test plan
- Reset, then check idle outputs. Then PUSH 0x11, 0x22, 0x33 on consecutive cycles. Required: count 1, 2, 3; `top` 0x11, 0x22, 0x33; `next` 0, 0x11, 0x22; `done` high for 3 cycles; `err` stays 0.
- Fill: DEPTH=8, push 0x01..0x08, then PUSH 0xFF. Required: `full` = 1, `err` pulse, `overflow` = 1, `top` stays 0x08, count stays 8.
- Pop an 8-deep stack nine times. Required: `top` 0x07..0x01 then 0, `empty` after the 8th pop, 9th pop gives `err` and `underflow` = 1. Then CLEAR: both sticky flags become 0.
- Stack {0xA0, 0xB0}: SWAP, DUP, then REPLACE 0x5C. Required: `top`/`next` go 0xA0/0xB0, then 0xA0/0xA0 with count 3, then 0x5C/0xA0 with count 3.
- On an empty stack: REPLACE, SWAP and DUP each give `err` and `underflow`; count stays 0. With one entry, SWAP gives `err` and the stack is unchanged.
- Assert `rst` on the same cycle as a PUSH with count 4. Required next cycle: count 0, `top` 0, `done` 0. A PUSH 0x42 afterwards gives count 1 and `top` 0x42.

Source files
------------

// File: rtl/stack_engine_if.sv
// Command and status bundle between the pin decode, the stack engine and the uo_out mux.
// The master drives commands; the slave (stack_engine) returns registered stack status.
interface stack_engine_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) ();
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] next;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             done;
    logic             err;
    logic             overflow;
    logic             underflow;

    modport master (
        output op_valid, op, data_in,
        input  top, next, count, empty, full, done, err, overflow, underflow
    );

    modport slave (
        input  op_valid, op, data_in,
        output top, next, count, empty, full, done, err, overflow, underflow
    );
endinterface

// File: rtl/stack_engine.sv
// WIDTH x DEPTH LIFO with push/pop/replace/dup/swap/clear, single-cycle commands,
// registered top/next views, completion/error pulses and sticky overflow/underflow.
module stack_engine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input logic           clk,
    input logic           rst,
    stack_engine_if.slave stk
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_DUP     = 3'd4,
        OP_SWAP    = 3'd5,
        OP_CLEAR   = 3'd6,
        OP_RSVD    = 3'd7
    } op_e;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    sp_q, sp_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic [WIDTH-1:0] next_q, next_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             is_empty;
    logic             is_full;
    logic             has_two;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    nxt_idx;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == CW'(DEPTH));
    assign has_two  = (sp_q >= CW'(2));
    assign wr_idx   = AW'(sp_q);
    assign top_idx  = AW'(sp_q - CW'(1));
    assign nxt_idx  = AW'(sp_q - CW'(2));

    // Command decode: a rejected command leaves array and pointer untouched.
    always_comb begin
        mem_d  = mem_q;
        sp_d   = sp_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        done_d = 1'b0;
        err_d  = 1'b0;

        if (stk.op_valid) begin
            case (op_e'(stk.op))
                OP_PUSH: begin
                    done_d = 1'b1;
                    if (is_full) begin
                        err_d = 1'b1;
                        ovf_d = 1'b1;
                    end else begin
                        mem_d[wr_idx] = stk.data_in;
                        sp_d          = sp_q + CW'(1);
                    end
                end
                OP_POP: begin
                    done_d = 1'b1;
                    if (is_empty) begin
                        err_d = 1'b1;
                        unf_d = 1'b1;
                    end else begin
                        sp_d = sp_q - CW'(1);
                    end
                end
                OP_REPLACE: begin
                    done_d = 1'b1;
                    if (is_empty) begin
                        err_d = 1'b1;
                        unf_d = 1'b1;
                    end else begin
                        mem_d[top_idx] = stk.data_in;
                    end
                end
                OP_DUP: begin
                    done_d = 1'b1;
                    if (is_empty) begin
                        err_d = 1'b1;
                        unf_d = 1'b1;
                    end else if (is_full) begin
                        err_d = 1'b1;
                        ovf_d = 1'b1;
                    end else begin
                        mem_d[wr_idx] = mem_q[top_idx];
                        sp_d          = sp_q + CW'(1);
                    end
                end
                OP_SWAP: begin
                    done_d = 1'b1;
                    if (!has_two) begin
                        err_d = 1'b1;
                        unf_d = 1'b1;
                    end else begin
                        mem_d[top_idx] = mem_q[nxt_idx];
                        mem_d[nxt_idx] = mem_q[top_idx];
                    end
                end
                OP_CLEAR: begin
                    done_d = 1'b1;
                    sp_d   = '0;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                end
                OP_NOP, OP_RSVD: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Status views derived from the post-update state so they align with done.
    always_comb begin
        top_d   = '0;
        next_d  = '0;
        empty_d = (sp_d == '0);
        full_d  = (sp_d == CW'(DEPTH));
        if (sp_d >= CW'(1)) begin
            top_d = mem_d[AW'(sp_d - CW'(1))];
        end
        if (sp_d >= CW'(2)) begin
            next_d = mem_d[AW'(sp_d - CW'(2))];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q    <= '0;
            top_q   <= '0;
            next_q  <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            top_q   <= top_d;
            next_q  <= next_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage array carries no reset; a command coincident with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= mem_d;
        end
    end

    assign stk.top       = top_q;
    assign stk.next      = next_q;
    assign stk.count     = sp_q;
    assign stk.empty     = empty_q;
    assign stk.full      = full_q;
    assign stk.done      = done_q;
    assign stk.err       = err_q;
    assign stk.overflow  = ovf_q;
    assign stk.underflow = unf_q;
endmodule

// File: tb/tb_stack_engine.sv
// Self-checking bench for stack_engine: directed scenarios plus randomized command
// streams, all compared against a queue-based reference stack.
module tb_stack_engine;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPL = 3'd3,
                           DUP = 3'd4, SWAP = 3'd5, CLR = 3'd6, RSVD = 3'd7;

    logic clk;
    logic rst;

    stack_engine_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    stack_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .stk (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [WIDTH-1:0] ms[$];
    bit m_ovf, m_unf, m_done, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit v, input logic [2:0] o, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] t;
        int sz;
        m_done = 1'b0;
        m_err  = 1'b0;
        sz = ms.size();
        if (!v || o == NOP || o == RSVD) return;
        m_done = 1'b1;
        case (o)
            PUSH: if (sz == DEPTH) begin m_err = 1; m_ovf = 1; end else ms.push_back(d);
            POP:  if (sz == 0) begin m_err = 1; m_unf = 1; end else void'(ms.pop_back());
            REPL: if (sz == 0) begin m_err = 1; m_unf = 1; end else ms[sz-1] = d;
            DUP: begin
                if (sz == 0) begin m_err = 1; m_unf = 1; end
                else if (sz == DEPTH) begin m_err = 1; m_ovf = 1; end
                else ms.push_back(ms[sz-1]);
            end
            SWAP: begin
                if (sz < 2) begin m_err = 1; m_unf = 1; end
                else begin t = ms[sz-1]; ms[sz-1] = ms[sz-2]; ms[sz-2] = t; end
            end
            CLR: begin ms.delete(); m_ovf = 0; m_unf = 0; end
            default: ;
        endcase
    endtask

    task automatic check_all();
        int sz;
        logic [WIDTH-1:0] et, en;
        sz = ms.size();
        et = (sz >= 1) ? ms[sz-1] : '0;
        en = (sz >= 2) ? ms[sz-2] : '0;
        check("top",       32'(bus.top),       32'(et));
        check("next",      32'(bus.next),      32'(en));
        check("count",     32'(bus.count),     32'(sz));
        check("empty",     32'(bus.empty),     32'(sz == 0));
        check("full",      32'(bus.full),      32'(sz == DEPTH));
        check("done",      32'(bus.done),      32'(m_done));
        check("err",       32'(bus.err),       32'(m_err));
        check("overflow",  32'(bus.overflow),  32'(m_ovf));
        check("underflow", 32'(bus.underflow), 32'(m_unf));
    endtask

    // One clock: drive at negedge, sample 1 ns after the rising edge.
    task automatic do_cmd(input bit v, input logic [2:0] o, input logic [WIDTH-1:0] d, input bit r);
        @(negedge clk);
        bus.op_valid = v;
        bus.op       = o;
        bus.data_in  = d;
        rst          = r;
        @(posedge clk);
        #1;
        if (r) begin
            ms.delete();
            m_ovf = 0; m_unf = 0; m_done = 0; m_err = 0;
        end else begin
            model_step(v, o, d);
        end
        check_all();
    endtask

    task automatic cmd(input logic [2:0] o, input logic [WIDTH-1:0] d);
        do_cmd(1'b1, o, d, 1'b0);
    endtask

    task automatic do_reset();
        do_cmd(1'b0, NOP, '0, 1'b1);
    endtask

    initial begin
        bus.op_valid = 1'b0;
        bus.op       = NOP;
        bus.data_in  = '0;
        rst          = 1'b1;

        do_reset();
        do_reset();
        do_cmd(1'b0, NOP, '0, 1'b0);
        check("idle_empty", 32'(bus.empty), 32'd1);

        // Three consecutive pushes
        cmd(PUSH, 8'h11);
        check("p1_top", 32'(bus.top), 32'h11);
        cmd(PUSH, 8'h22);
        check("p2_next", 32'(bus.next), 32'h11);
        cmd(PUSH, 8'h33);
        check("p3_top", 32'(bus.top), 32'h33);
        check("p3_cnt", 32'(bus.count), 32'd3);

        // Fill then overflow
        cmd(CLR, '0);
        for (int i = 1; i <= 8; i++) cmd(PUSH, WIDTH'(i));
        cmd(PUSH, 8'hFF);
        check("ovf_top",  32'(bus.top), 32'h08);
        check("ovf_cnt",  32'(bus.count), 32'd8);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        cmd(DUP, '0);

        // Drain past empty, then clear sticky flags
        for (int i = 1; i <= 9; i++) begin
            cmd(POP, '0);
            if (i <= 7) check("pop_top", 32'(bus.top), 32'(8 - i));
        end
        check("unf_flag", 32'(bus.underflow), 32'd1);
        check("unf_err",  32'(bus.err), 32'd1);
        cmd(CLR, '0);
        check("clr_ovf", 32'(bus.overflow), 32'd0);
        check("clr_unf", 32'(bus.underflow), 32'd0);

        // Swap / dup / replace
        cmd(PUSH, 8'hA0);
        cmd(PUSH, 8'hB0);
        cmd(SWAP, '0);
        check("swap_top",  32'(bus.top),  32'hA0);
        check("swap_next", 32'(bus.next), 32'hB0);
        cmd(DUP, '0);
        check("dup_next", 32'(bus.next), 32'hA0);
        check("dup_cnt",  32'(bus.count), 32'd3);
        cmd(REPL, 8'h5C);
        check("repl_top", 32'(bus.top), 32'h5C);

        // Errors on empty and single-entry stacks
        cmd(CLR, '0);
        cmd(REPL, 8'h99);
        cmd(SWAP, '0);
        cmd(DUP, '0);
        check("empty_dup_err", 32'(bus.err), 32'd1);
        cmd(PUSH, 8'h77);
        cmd(SWAP, '0);
        check("one_swap_top", 32'(bus.top), 32'h77);
        cmd(RSVD, 8'h12);
        do_cmd(1'b0, PUSH, 8'h13, 1'b0);

        // Reset colliding with a push
        cmd(CLR, '0);
        for (int i = 0; i < 4; i++) cmd(PUSH, WIDTH'(8'h30 + i));
        do_cmd(1'b1, PUSH, 8'hEE, 1'b1);
        check("rst_cnt",  32'(bus.count), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        cmd(PUSH, 8'h42);
        check("post_rst_top", 32'(bus.top), 32'h42);

        // Randomized command stream with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] o;
            bit v, r;
            o = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) o = PUSH;
            if ($urandom_range(0, 60) == 0) o = CLR;
            v = ($urandom_range(0, 9) != 0);
            r = ($urandom_range(0, 150) == 0);
            do_cmd(v, o, WIDTH'($urandom), r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
